// File: rtl/alu_pkg.sv
// Shared types and opcode constants for the ALU core and its adder.
package alu_pkg;

  typedef logic [31:0] u32;
  typedef logic [2:0]  u3;
  typedef logic        u1;

  // Full opcodes. Bit 2 inverts B; bits 1:0 pick the AND, OR, adder or SLT path.
  localparam u3 ALU_AND  = 3'b000;
  localparam u3 ALU_OR   = 3'b001;
  localparam u3 ALU_ADD  = 3'b010;
  localparam u3 ALU_RSVD = 3'b011;
  localparam u3 ALU_RAND = 3'b100;
  localparam u3 ALU_ROR  = 3'b101;
  localparam u3 ALU_SUB  = 3'b110;
  localparam u3 ALU_SLT  = 3'b111;

  // Path selects taken from opcode bits 1:0.
  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b10;
  localparam logic [1:0] SEL_SLT = 2'b11;

endpackage

// File: rtl/alu_adder.sv
// WIDTH-bit adder shared by ADD, SUB and SLT; reports carry-out and signed overflow.
module alu_adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_inv,
  input  u1                cin,
  output logic [WIDTH-1:0] sum,
  output u1                cout,
  output u1                overflow
);

  // One extra bit catches the carry-out of the WIDTH-bit addition.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b_inv} + (WIDTH+1)'(cin);
  end

  // Signed overflow: both addends share a sign that the sum does not.
  always_comb begin
    overflow = (a[WIDTH-1] == b_inv[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_core.sv
// Single-cycle ALU with a registered result and zero flag; synchronous active-low reset.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  u3                ALUcont,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic [WIDTH-1:0] b_inv_c;
  logic [WIDTH-1:0] sum_c;
  u1                adder_cout_unused;
  u1                ovf_c;
  u1                slt_less_c;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  u1                zero_d;
  u1                zero_q;

  // Opcode bit 2 inverts B; together with cin=1 this turns the adder into A-B.
  always_comb begin
    b_inv_c = ALUcont[2] ? ~B : B;
  end

  alu_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a        (A),
    .b_inv    (b_inv_c),
    .cin      (ALUcont[2]),
    .sum      (sum_c),
    .cout     (adder_cout_unused),
    .overflow (ovf_c)
  );

  // Signed less-than stays correct when A-B overflows.
  always_comb begin
    slt_less_c = sum_c[WIDTH-1] ^ ovf_c;
  end

  // Result mux; opcode 011 (adder-free SLT slot without inversion) yields zero.
  always_comb begin
    result_d = '0;
    case (ALUcont[1:0])
      SEL_AND: result_d = A & b_inv_c;
      SEL_OR:  result_d = A | b_inv_c;
      SEL_ADD: result_d = sum_c;
      SEL_SLT: result_d = ALUcont[2] ? WIDTH'(slt_less_c) : '0;
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  // Output register; reset forces result=0 and zero=1, discarding the sampled op.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed scenarios plus random ops against a reference model.
module tb_alu_core;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             resetn;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUcont;
  logic [WIDTH-1:0] result;
  logic             zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_core #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .A       (A),
    .B       (B),
    .ALUcont (ALUcont),
    .result  (result),
    .zero    (zero)
  );

  // Reference model written directly from the opcode definitions.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUcont = op;
    A       = a;
    B       = b;
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(ALU_OR, 32'hDEAD_BEEF, 32'h1234_5678);
    step();
    step();
    n_checks++;
    if (result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_result got=%h want=%h", result, 32'd0);
    end
    n_checks++;
    if (zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_zero got=%b want=1", zero);
    end
    resetn = 1'b1;
  endtask

  task automatic test_chain();
    logic [2:0]  ops [6] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_RAND, ALU_ROR, ALU_SUB};
    logic [31:0] as  [6] = '{32'd2, 32'd2, 32'd6, 32'd9, 32'd8, 32'd15};
    logic [31:0] bs  [6] = '{32'd7, 32'd4, 32'd3, 32'd1, 32'hFFFF_FFF8, 32'd4};
    logic [31:0] ex  [6] = '{32'd2, 32'd6, 32'd9, 32'd8, 32'd15, 32'd11};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], as[i], bs[i]);
      step();
      n_checks++;
      if (result !== ex[i] || zero !== 1'b0) begin
        n_fail++;
        $display("FAIL chain_%0d got=%h/z%b want=%h/z0", i, result, zero, ex[i]);
      end
    end
  endtask

  task automatic test_slt_sub();
    logic [2:0]  ops [5] = '{ALU_SLT, ALU_SLT, ALU_ADD, ALU_SUB, ALU_SUB};
    logic [31:0] as  [5] = '{32'd11, 32'd11, 32'd11, 32'd44, 32'd22};
    logic [31:0] bs  [5] = '{32'd12, 32'd11, 32'd33, 32'd22, 32'd22};
    logic [31:0] ex  [5] = '{32'd1, 32'd0, 32'd44, 32'd22, 32'd0};
    logic        ez  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], as[i], bs[i]);
      step();
      n_checks++;
      if (result !== ex[i] || zero !== ez[i]) begin
        n_fail++;
        $display("FAIL slt_sub_%0d got=%h/z%b want=%h/z%b", i, result, zero, ex[i], ez[i]);
      end
    end
  endtask

  task automatic test_signed();
    logic [2:0]  ops [4] = '{ALU_SLT, ALU_SLT, ALU_ADD, ALU_RSVD};
    logic [31:0] as  [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] bs  [4] = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'd5};
    logic [31:0] ex  [4] = '{32'd1, 32'd0, 32'd0, 32'd0};
    logic        ez  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], as[i], bs[i]);
      step();
      n_checks++;
      if (result !== ex[i] || zero !== ez[i]) begin
        n_fail++;
        $display("FAIL signed_%0d got=%h/z%b want=%h/z%b", i, result, zero, ex[i], ez[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(ALU_OR, 32'd12, 32'd3);
    step();
    resetn = 1'b0;
    drive(ALU_ADD, 32'd1, 32'd2);
    step();
    n_checks++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_hold got=%h/z%b want=0/z1", result, zero);
    end
    resetn = 1'b1;
    step();
    n_checks++;
    if (result !== 32'd3 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release got=%h/z%b want=3/z0", result, zero);
    end
  endtask

  task automatic test_latency();
    drive(ALU_ADD, 32'd1, 32'd1);
    step();
    n_checks++;
    if (result !== 32'd2) begin
      n_fail++;
      $display("FAIL latency_first got=%h want=%h", result, 32'd2);
    end
    #2;
    A = 32'd5;
    #1;
    n_checks++;
    if (result !== 32'd2 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_midcycle got=%h/z%b want=2/z0", result, zero);
    end
    step();
    n_checks++;
    if (result !== 32'd6) begin
      n_fail++;
      $display("FAIL latency_next_edge got=%h want=%h", result, 32'd6);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      e  = ref_alu(op, a, b);
      drive(op, a, b);
      step();
      n_checks++;
      if (result !== e || zero !== (e == 32'd0)) begin
        n_fail++;
        $display("FAIL b2b_%0d op=%0d got=%h/z%b want=%h", i, op, result, zero, e);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
      logic        rn;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = a;
        1:       b = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      rn = ($urandom_range(0, 63) != 0);
      e  = rn ? ref_alu(op, a, b) : 32'd0;
      resetn = rn;
      drive(op, a, b);
      step();
      n_checks++;
      if (result !== e || zero !== (e == 32'd0)) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d rn=%b a=%h b=%h got=%h/z%b want=%h",
                 i, op, rn, a, b, result, zero, e);
      end
    end
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    A       = '0;
    B       = '0;
    ALUcont = '0;
    #1;
    test_reset();
    test_chain();
    test_slt_sub();
    test_signed();
    test_reset_midstream();
    test_latency();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter WIDTH, default 32: datapath width; all arithmetic rules below are stated for WIDTH=32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 A  input  WIDTH  first operand.
REQ-005 B  input  WIDTH  second operand.
REQ-006 ALUcont  input  3  operation select.
REQ-007 result  output  WIDTH  registered operation result.
REQ-008 zero  output  1  registered flag, 1 when result is all zeros.

Function
REQ-009 The ALU SHALL use opcodes 000 AND (A&B), 001 OR (A|B), 010 ADD (A+B), 011 reserved, 100 RAND (A&~B), 101 ROR (A|~B), 110 SUB (A-B), 111 SLT.
REQ-010 ADD and SUB SHALL be modulo 2^WIDTH, with carry and overflow discarded.
REQ-011 SUB SHALL be computed as A + ~B + 1 on the shared adder.
REQ-012 SLT SHALL output 1 when A < B as signed two's complement, else 0, zero-extended to WIDTH.
REQ-013 SLT SHALL give the correct signed result under subtraction overflow: less = sign(A-B) XOR overflow.
REQ-014 Reserved opcode 011 SHALL produce result 0, and therefore zero=1.
REQ-015 On each rising edge of clk with resetn=1, result SHALL load f(A,B,ALUcont) computed from the values sampled at that edge; latency is 1 cycle.
REQ-016 zero SHALL be registered together with result, so that zero == (result == 0) holds in every cycle.
REQ-017 Outputs SHALL hold their value between edges and change only on a rising edge.
REQ-018 The block SHALL have no handshake: a new operation may be issued every cycle, giving a throughput of one per cycle.
REQ-019 Changing inputs between edges SHALL have no effect on the outputs until the next rising edge.

Reset
REQ-020 While resetn=0 at a rising edge, result SHALL become 0 and zero SHALL become 1, with the inputs ignored.
REQ-021 Reset asserted mid-stream SHALL discard the operation sampled at that edge.
REQ-022 The first edge after resetn returns to 1 SHALL load a normal result.
REQ-023 The block SHALL have no asynchronous reset path.

Structure
REQ-024 A shared package alu_pkg SHALL hold the typedefs u32, u3 and u1 and the opcode constants ALU_AND, ALU_OR, ALU_ADD, ALU_RAND, ALU_ROR, ALU_SUB and ALU_SLT.
REQ-025 One sub-module alu_adder SHALL contain the WIDTH-bit adder with inputs a, b_inv (B, or ~B when ALUcont[2]=1) and cin=ALUcont[2].
REQ-026 alu_adder SHALL provide outputs sum, cout and overflow.
REQ-027 Opcode bit 2 SHALL select B inversion for RAND, ROR, SUB and SLT; bits 1:0 SHALL select the AND, OR, adder or SLT path.
REQ-028 The output register and the zero flag SHALL reside in alu_core.

Verification
REQ-029 Chain with a one-cycle check after each op: AND 2,7 -> 2; OR 2,4 -> 6; ADD 6,3 -> 9; RAND 9,1 -> 8; ROR 8,0xFFFFFFF8 -> 15; SUB 15,4 -> 11; result never 0 and zero=0 throughout.
REQ-030 SLT 11,12 -> 1; SLT 11,11 -> 0, zero=1; ADD 11,33 -> 44; SUB 44,22 -> 22; SUB 22,22 -> 0, zero=1.
REQ-031 Signed and overflow: SLT 0x80000000,1 -> 1; SLT 0x7FFFFFFF,0xFFFFFFFF -> 0; ADD 0xFFFFFFFF,1 -> 0, zero=1; reserved 011 with 5,5 -> 0, zero=1.
REQ-032 Reset: resetn=0 for one edge with ADD 1,2 applied -> result 0, zero=1; on the next edge with resetn=1 -> result 3, zero=0.
REQ-033 Latency: change A mid-cycle -> outputs unchanged until the next rising edge; back-to-back ops on consecutive edges each return the correct value one cycle later.
REQ-034 Random: 10,000 random A, B and ALUcont against a reference model, checking result and zero every cycle.
